// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with optional first-word-fall-through read,
// almost-full/empty thresholds, occupancy count and sticky error flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_enable,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ovf, r_udf;
  logic                  w_wr, w_rd;
  assign w_wr = w_enable && !full;
  assign w_rd = r_enable && !empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr != w_rd) r_count <= w_wr ? r_count + 1'b1 : r_count - 1'b1;
      if (w_rd) r_rdata <= r_mem[r_rd_ptr];
      r_ovf <= (w_enable && full) || (r_ovf && !err_clr);
      r_udf <= (r_enable && empty) || (r_udf && !err_clr);
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_data;
  end
  assign r_data       = (FWFT != 0) ? r_mem[r_rd_ptr] : r_rdata;
  assign count        = r_count;
  assign empty        = r_count == '0;
  assign full         = r_count == (ADDR_WIDTH + 1)'(DEPTH);
  assign almost_empty = r_count <= (ADDR_WIDTH + 1)'(AE_THRESH);
  assign almost_full  = r_count >= (ADDR_WIDTH + 1)'(AF_THRESH);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of a standard-read and an FWFT instance driven in lockstep.
module tb_sync_fifo;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [23:0] wd = '0;
  logic [23:0] rd, rdf;
  logic        emp, ful, ae, af, ovf, udf;
  logic        emp_f, ful_f, ae_f, af_f, ovf_f, udf_f;
  logic [4:0]  cnt, cnt_f;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  sync_fifo #(.FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .w_enable(we), .w_data(wd), .r_enable(re), .err_clr(clr),
    .r_data(rd), .empty(emp), .full(ful), .almost_empty(ae), .almost_full(af),
    .count(cnt), .overflow(ovf), .underflow(udf)
  );
  sync_fifo #(.FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .w_enable(we), .w_data(wd), .r_enable(re), .err_clr(clr),
    .r_data(rdf), .empty(emp_f), .full(ful_f), .almost_empty(ae_f), .almost_full(af_f),
    .count(cnt_f), .overflow(ovf_f), .underflow(udf_f)
  );
  typedef struct {
    logic        we;
    logic [23:0] wd;
    logic        re;
    logic        clr;
    logic [4:0]  cnt;
    logic        emp;
    logic        ovf;
    logic        udf;
    logic [23:0] rd;
    logic        chkf;
    logic [23:0] rdf;
  } vec_t;
  vec_t vecs [7];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic cyc(input logic w, input logic [23:0] d, input logic r, input logic c);
    @(negedge clk);
    we = w; wd = d; re = r; clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_cnt"}, 32'(cnt), 0);
    chk({n, "_empty"}, 32'(emp), 1);
    chk({n, "_full"}, 32'(ful), 0);
    chk({n, "_ae"}, 32'(ae), 1);
    chk({n, "_af"}, 32'(af), 0);
    chk({n, "_ovf"}, 32'(ovf), 0);
    chk({n, "_udf"}, 32'(udf), 0);
    chk({n, "_rdata"}, 32'(rd), 0);
  endtask
  initial begin
    vecs[0] = '{1'b1, 24'hABCDEF, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 24'h00001D, 1'b1, 24'hABCDEF};
    vecs[1] = '{1'b0, 24'h0,      1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 24'hABCDEF, 1'b0, 24'h0};
    vecs[2] = '{1'b1, 24'h000055, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 24'hABCDEF, 1'b1, 24'h000055};
    vecs[3] = '{1'b0, 24'h0,      1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 1'b1, 24'h000055};
    vecs[4] = '{1'b0, 24'h0,      1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 24'h000055, 1'b0, 24'h0};
    vecs[5] = '{1'b0, 24'h0,      1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 24'h000055, 1'b0, 24'h0};
    vecs[6] = '{1'b0, 24'h0,      1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 24'h000055, 1'b0, 24'h0};
    #3;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 24'(i), 1'b0, 1'b0);
      chk("fill_cnt", 32'(cnt), 32'(i));
      chk("fill_full", 32'(ful), 32'(i == 16));
      chk("fill_af", 32'(af), 32'(i >= 14));
      chk("fill_ae", 32'(ae), 32'(i <= 2));
    end
    cyc(1'b1, 24'd17, 1'b0, 1'b0);
    chk("ovf_cnt", 32'(cnt), 16);
    chk("ovf_set", 32'(ovf), 1);
    cyc(1'b0, 24'd0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf), 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 24'd0, 1'b1, 1'b0);
      chk("drain_data", 32'(rd), 32'(i));
      chk("drain_cnt", 32'(cnt), 32'(16 - i));
      chk("drain_empty", 32'(emp), 32'(i == 16));
      chk("drain_ae", 32'(ae), 32'(16 - i <= 2));
    end
    cyc(1'b0, 24'd0, 1'b1, 1'b0);
    chk("udf_set", 32'(udf), 1);
    chk("udf_hold", 32'(rd), 16);
    cyc(1'b0, 24'd0, 1'b0, 1'b1);
    chk("udf_clr", 32'(udf), 0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; k++) begin
        cyc(1'b1, 24'(r * 10 + k), 1'b0, 1'b0);
        chk("wrap_wcnt", 32'(cnt), 32'(k + 1));
      end
      for (int k = 0; k < 10; k++) begin
        cyc(1'b0, 24'd0, 1'b1, 1'b0);
        chk("wrap_data", 32'(rd), 32'(r * 10 + k));
        chk("wrap_rcnt", 32'(cnt), 32'(9 - k));
      end
    end
    for (int i = 0; i < 7; i++) begin
      cyc(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].clr);
      chk("vec_cnt", 32'(cnt), 32'(vecs[i].cnt));
      chk("vec_empty", 32'(emp), 32'(vecs[i].emp));
      chk("vec_ovf", 32'(ovf), 32'(vecs[i].ovf));
      chk("vec_udf", 32'(udf), 32'(vecs[i].udf));
      chk("vec_rdata", 32'(rd), 32'(vecs[i].rd));
      chk("vec_fwft_empty", 32'(emp_f), 32'(vecs[i].emp));
      if (vecs[i].chkf) chk("vec_fwft_rdata", 32'(rdf), 32'(vecs[i].rdf));
    end
    for (int i = 0; i < 16; i++) cyc(1'b1, 24'h100 + 24'(i), 1'b0, 1'b0);
    chk("full2", 32'(ful), 1);
    cyc(1'b1, 24'h999, 1'b1, 1'b0);
    chk("simul_full_data", 32'(rd), 32'h100);
    chk("simul_full_cnt", 32'(cnt), 15);
    chk("simul_full_ovf", 32'(ovf), 1);
    cyc(1'b1, 24'h110, 1'b0, 1'b0);
    chk("refill_full", 32'(ful), 1);
    cyc(1'b1, 24'h888, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(ovf), 1);
    chk("ovf_set_wins_cnt", 32'(cnt), 16);
    cyc(1'b0, 24'd0, 1'b0, 1'b1);
    chk("ovf_clr2", 32'(ovf), 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 24'd0, 1'b1, 1'b0);
      chk("drain2_data", 32'(rd), 32'h100 + 32'(i));
    end
    chk("drain2_empty", 32'(emp), 1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 24'h200 + 24'(i), 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(cnt), 7);
    #2;
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; clr = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 24'h777, 1'b0, 1'b0);
    chk("post_rst_cnt", 32'(cnt), 1);
    chk("post_rst_fwft", 32'(rdf), 32'h777);
    cyc(1'b0, 24'd0, 1'b1, 1'b0);
    chk("post_rst_data", 32'(rd), 32'h777);
    chk("post_rst_empty", 32'(emp), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
